key_sched_ctrl: RTL and testbench
=================================

// Module: key_sched_ctrl
// PURPOSE
//   Sequences the gen_key round-key datapath through all ten AES-128 expansion rounds.
//   Accepts a cipher key over a valid/ready handshake and feeds each round key back into gen_key.
//   Stores all 11 round keys (rk[0..10]) in an internal register file.
//   Serves them to the cipher round datapath through a registered read port.
// PARAMETERS
//   KEY_W      128  round-key width (fixed for AES-128)
//   NUM_ROUNDS 10   expansion rounds; rk file depth = NUM_ROUNDS+1
//   GEN_LAT    2    cycles from gen_key round/key_in change to key_out valid (sbox reg + out reg)
// PORTS
//   clk          in   1      single clock, all logic on posedge
//   rst_n        in   1      asynchronous, active-low reset
//   key_valid    in   1      cipher_key offered
//   key_ready    out  1      controller can accept; high only in IDLE
//   cipher_key   in   KEY_W  initial key; sampled on key_valid&key_ready edge
//   clear        in   1      synchronous abort/invalidate, any state
//   busy         out  1      expansion in progress (WAIT or STORE)
//   done         out  1      one-cycle pulse: rk[10] written
//   keys_valid   out  1      level: rk[0..10] complete and consistent with last accepted key
//   rk_rd_addr   in   4      round-key index 0..10
//   rk_rd_data   out  KEY_W  rk[rk_rd_addr], registered, 1-cycle latency
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - state=IDLE, round=0, wait counter=0.
//     - All rk entries and rk_rd_data = 0.
//     - key_ready=1 after reset release; busy=0, done=0, keys_valid=0.
//   States:
//     - IDLE: key_ready=1. On accept edge E: rk[0]<=cipher_key, cur_key<=cipher_key,
//       round<=0, keys_valid<=0, go to WAIT.
//     - WAIT: gen_key round=round, key_in=cur_key, held stable.
//       Counter runs GEN_LAT cycles, then go to STORE.
//     - STORE: 1 cycle. On its closing edge: rk[round+1]<=gen_key key_out,
//       cur_key<=key_out, round<=round+1.
//       If round==NUM_ROUNDS-1: go to IDLE, done<=1, keys_valid<=1. Otherwise go to WAIT.
//   Timing:
//     - Each round takes GEN_LAT+1 cycles.
//     - rk[10] is written at edge E+NUM_ROUNDS*(GEN_LAT+1) (E+30 by default).
//     - done is high for exactly the following cycle.
//   Round index: round is 4 bits, 0..9 only, and is passed directly as the gen_key round
//     input (rcon index 0 = 0x01). It never wraps past 9.
//   Handshake:
//     - key_valid while not IDLE is ignored; the offered key is not consumed.
//     - key_valid held high through done is accepted on the first IDLE cycle after done.
//   clear:
//     - Next edge: state=IDLE, keys_valid=0, done=0, round=0. rk contents are left unchanged.
//     - clear wins over a simultaneous accept: that key is not consumed.
//     - clear in the same cycle as the final STORE: done and keys_valid stay 0.
//   Read port:
//     - rk_rd_data <= rk[rk_rd_addr] every edge, in every state.
//     - rk_rd_addr>10 returns 0.
//     - Reads during busy return whatever the entry currently holds; consumers gate on keys_valid.
//   Reset mid-operation: immediate abort to reset values. No partial state survives.
// STRUCTURE
//   Shared package aes_pkg: KEY_W, NUM_ROUNDS, GEN_LAT, state encoding (IDLE/WAIT/STORE), RK_DEPTH=11.
//   One sub-module: gen_key instance u_gen_key, driven by clk, with round/key_in/key_out
//     wired to the controller registers.
//   rk file: 11 x KEY_W flops (no RAM), written only in STORE and on accept.
// TESTING
//   1. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c -> done at E+30;
//      rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
//   2. All-zero key -> rk[1]=62636363626363636263636362636363, rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
//   3. key_valid held during busy with a second key -> key_ready=0 throughout, second key
//      accepted the cycle after done, keys_valid drops at that edge, new rk[10] correct.
//   4. clear pulsed at cycle E+10 -> IDLE next edge, no done, keys_valid=0;
//      a re-issued key then expands correctly.
//   5. rst_n low at E+15 -> all outputs 0 and rk_rd_data=0 immediately; key_ready=1 after release.
//   6. Read sweep addr 0..15 after done -> 1-cycle latency, entries 0..10 match the model, 11..15 return 0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule constants, FSM encoding and GF(2^8) helpers.
// The S-box is computed as multiplicative inverse plus affine transform rather than tabulated.
package aes_pkg;

  localparam int unsigned KEY_W      = 128;
  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned GEN_LAT    = 2;
  localparam int unsigned RK_DEPTH   = NUM_ROUNDS + 1;
  localparam int unsigned CNT_W      = $clog2(GEN_LAT + 1);
  localparam int unsigned ST_W       = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_WAIT  = 2'd1;
  localparam logic [ST_W-1:0] ST_STORE = 2'd2;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the field inverse for x != 0 and yields 0 for x == 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      if (e[i]) r = gf_mul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/key_sched_ctrl_gen_key.sv
// One AES-128 key-expansion round: registered SubWord/RotWord/Rcon term, then registered output.
// key_in and round must be held stable for GEN_LAT cycles before key_out is used.
module gen_key
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       round,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_out
);

  logic [31:0]      temp_q, temp_d;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      n0, n1, n2, n3;

  always_comb begin
    w0 = key_in[127:96];
    w1 = key_in[95:64];
    w2 = key_in[63:32];
    w3 = key_in[31:0];
    temp_d = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round), 24'h000000};
    n0 = w0 ^ temp_q;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    key_out_d = {n0, n1, n2, n3};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_q    <= '0;
      key_out_q <= '0;
    end else begin
      temp_q    <= temp_d;
      key_out_q <= key_out_d;
    end
  end

  assign key_out = key_out_q;

endmodule

// File: rtl/key_sched_ctrl.sv
// AES-128 key-schedule sequencer: accepts a cipher key, iterates gen_key ten times,
// stores rk[0..10] in flops and serves them through a registered read port.
module key_sched_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [KEY_W-1:0] cipher_key,
  input  logic             clear,
  output logic             busy,
  output logic             done,
  output logic             keys_valid,
  input  logic [3:0]       rk_rd_addr,
  output logic [KEY_W-1:0] rk_rd_data
);

  logic [ST_W-1:0]  state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] cur_key_q, cur_key_d;
  logic [KEY_W-1:0] rk_q [RK_DEPTH];
  logic [KEY_W-1:0] rk_d [RK_DEPTH];
  logic             done_q, done_d;
  logic             keys_valid_q, keys_valid_d;
  logic             key_ready_q, key_ready_d;
  logic             busy_q, busy_d;
  logic [KEY_W-1:0] rk_rd_data_q, rk_rd_data_d;
  logic [KEY_W-1:0] gen_key_out;

  gen_key u_gen_key (
    .clk     (clk),
    .rst_n   (rst_n),
    .round   (round_q),
    .key_in  (cur_key_q),
    .key_out (gen_key_out)
  );

  // Next-state, rk-file update and read-port logic
  always_comb begin
    state_d      = state_q;
    round_d      = round_q;
    cnt_d        = cnt_q;
    cur_key_d    = cur_key_q;
    rk_d         = rk_q;
    done_d       = 1'b0;
    keys_valid_d = keys_valid_q;

    if (clear) begin
      state_d      = ST_IDLE;
      round_d      = 4'd0;
      cnt_d        = '0;
      keys_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_valid && key_ready_q) begin
            rk_d[0]      = cipher_key;
            cur_key_d    = cipher_key;
            round_d      = 4'd0;
            cnt_d        = '0;
            keys_valid_d = 1'b0;
            state_d      = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_q == CNT_W'(GEN_LAT - 1)) begin
            cnt_d   = '0;
            state_d = ST_STORE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_STORE: begin
          rk_d[round_q + 4'd1] = gen_key_out;
          cur_key_d            = gen_key_out;
          if (round_q == 4'(NUM_ROUNDS - 1)) begin
            round_d      = 4'd0;
            done_d       = 1'b1;
            keys_valid_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = ST_WAIT;
          end
        end
        default: begin
          state_d = ST_IDLE;
          round_d = 4'd0;
          cnt_d   = '0;
        end
      endcase
    end

    key_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d == ST_WAIT) || (state_d == ST_STORE);
    rk_rd_data_d = (rk_rd_addr < 4'(RK_DEPTH)) ? rk_q[rk_rd_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      round_q      <= 4'd0;
      cnt_q        <= '0;
      cur_key_q    <= '0;
      done_q       <= 1'b0;
      keys_valid_q <= 1'b0;
      key_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      rk_rd_data_q <= '0;
      for (int i = 0; i < int'(RK_DEPTH); i++) rk_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      round_q      <= round_d;
      cnt_q        <= cnt_d;
      cur_key_q    <= cur_key_d;
      done_q       <= done_d;
      keys_valid_q <= keys_valid_d;
      key_ready_q  <= key_ready_d;
      busy_q       <= busy_d;
      rk_rd_data_q <= rk_rd_data_d;
      for (int i = 0; i < int'(RK_DEPTH); i++) rk_q[i] <= rk_d[i];
    end
  end

  assign key_ready  = key_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign keys_valid = keys_valid_q;
  assign rk_rd_data = rk_rd_data_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl: known-answer table, random keys against a
// word-level key-expansion model, plus handshake, clear and reset corner sequences.
module tb_key_sched_ctrl;

  logic         clk;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] cipher_key;
  logic         clear;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_rd_addr;
  logic [127:0] rk_rd_data;

  int checks;
  int failures;

  logic [7:0]   sbox_t [256];
  logic [127:0] m_rk [11];

  typedef struct {
    logic [127:0] key;
    logic [127:0] rk1;
    logic [127:0] rk10;
  } vec_t;

  vec_t tv [5];

  key_sched_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .cipher_key (cipher_key),
    .clear      (clear),
    .busy       (busy),
    .done       (done),
    .keys_valid (keys_valid),
    .rk_rd_addr (rk_rd_addr),
    .rk_rd_data (rk_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d;
    d = {v, v} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // S-box built by walking generator 3 and its inverse through the field
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic rand_key(output logic [127:0] k);
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic accept(input logic [127:0] key);
    chk("ready_before_accept", 128'(key_ready), 128'd1);
    key_valid  = 1'b1;
    cipher_key = key;
    tick();
    key_valid  = 1'b0;
    chk("busy_after_accept", 128'(busy), 128'd1);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 60);
    chk(name, 128'(n), 128'd30);
    chk("keys_valid_at_done", 128'(keys_valid), 128'd1);
    chk("busy_at_done", 128'(busy), 128'd0);
  endtask

  task automatic rd(input int addr, output logic [127:0] data);
    rk_rd_addr = 4'(addr);
    tick();
    data = rk_rd_data;
  endtask

  task automatic sweep();
    logic [127:0] d;
    logic [127:0] e;
    for (int a = 0; a < 16; a++) begin
      rd(a, d);
      e = (a <= 10) ? m_rk[a] : 128'd0;
      chk($sformatf("sweep_rk%0d", a), d, e);
    end
  endtask

  initial begin
    logic [127:0] d, ka, kb, k, prev10, k3;
    int n, rdy_seen, done_seen;
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    key_valid = 1'b0;
    cipher_key = '0;
    clear = 1'b0;
    rk_rd_addr = 4'd0;
    build_sbox();

    tv[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
              128'ha0fafe1788542cb123a339392a6c7605,
              128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tv[1] = '{128'h0,
              128'h62636363626363636263636362636363,
              128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    for (int i = 2; i < 5; i++) begin
      rand_key(k);
      model_expand(k);
      tv[i] = '{k, m_rk[1], m_rk[10]};
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_keys_valid", 128'(keys_valid), 128'd0);
    chk("rst_rd_data", rk_rd_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_key_ready", 128'(key_ready), 128'd1);

    // Known-answer and random-key table
    for (int i = 0; i < 5; i++) begin
      model_expand(tv[i].key);
      accept(tv[i].key);
      wait_done($sformatf("done_lat_v%0d", i));
      tick();
      chk("done_one_cycle", 128'(done), 128'd0);
      rd(1, d);
      chk($sformatf("v%0d_rk1", i), d, tv[i].rk1);
      rd(10, d);
      chk($sformatf("v%0d_rk10", i), d, tv[i].rk10);
      sweep();
    end

    // Second key held through busy, accepted right after done
    rand_key(ka);
    rand_key(kb);
    accept(ka);
    key_valid = 1'b1;
    cipher_key = kb;
    n = 0;
    rdy_seen = 0;
    do begin
      tick();
      n++;
      if (key_ready && !done) rdy_seen++;
    end while (!done && n < 60);
    chk("hold_done_lat", 128'(n), 128'd30);
    chk("hold_ready_low", 128'(rdy_seen), 128'd0);
    chk("hold_kv_at_done", 128'(keys_valid), 128'd1);
    tick();
    key_valid = 1'b0;
    chk("hold_kv_drop", 128'(keys_valid), 128'd0);
    chk("hold_busy", 128'(busy), 128'd1);
    chk("hold_ready", 128'(key_ready), 128'd0);
    wait_done("hold_second_lat");
    model_expand(kb);
    rd(10, d);
    chk("hold_rk10", d, m_rk[10]);
    rd(0, d);
    chk("hold_rk0", d, kb);

    // clear mid-expansion
    rand_key(k);
    accept(k);
    repeat (9) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", 128'(busy), 128'd0);
    chk("clr_ready", 128'(key_ready), 128'd1);
    chk("clr_kv", 128'(keys_valid), 128'd0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) done_seen++;
      tick();
    end
    chk("clr_no_done", 128'(done_seen), 128'd0);
    rand_key(ka);
    key_valid = 1'b1;
    cipher_key = ka;
    clear = 1'b1;
    tick();
    key_valid = 1'b0;
    clear = 1'b0;
    chk("clr_wins_busy", 128'(busy), 128'd0);
    rd(0, d);
    chk("clr_wins_rk0", d, k);
    rand_key(k);
    model_expand(k);
    accept(k);
    wait_done("clr_reissue_lat");
    sweep();

    // clear coinciding with the final STORE
    prev10 = m_rk[10];
    rand_key(k3);
    model_expand(k3);
    accept(k3);
    repeat (29) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_last_done", 128'(done), 128'd0);
    chk("clr_last_kv", 128'(keys_valid), 128'd0);
    rd(10, d);
    chk("clr_last_rk10_kept", d, prev10);
    rd(1, d);
    chk("clr_last_rk1", d, m_rk[1]);

    // Asynchronous reset mid-expansion
    rand_key(k);
    accept(k);
    repeat (15) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 128'(key_ready), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_done", 128'(done), 128'd0);
    chk("mid_rst_kv", 128'(keys_valid), 128'd0);
    chk("mid_rst_rd", rk_rd_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 128'(key_ready), 128'd1);
    rd(0, d);
    chk("post_rst_rk0", d, 128'd0);
    rd(5, d);
    chk("post_rst_rk5", d, 128'd0);
    rand_key(k);
    model_expand(k);
    accept(k);
    wait_done("post_rst_lat");
    sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
